// File: rtl/mac_pkg.sv
// Shared types and defaults for the shift-and-add MAC sequencer.
package mac_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned ACC_W_DEF = 20;
    localparam int unsigned LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL,
        ACC,
        DONE
    } state_t;

    // Width of the per-pair bit counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job control, operand stream and result handshake of the MAC sequencer.
interface mac_seq_ctrl_if #(
    parameter int unsigned W     = mac_pkg::W_DEF,
    parameter int unsigned ACC_W = mac_pkg::ACC_W_DEF,
    parameter int unsigned LEN_W = mac_pkg::LEN_W_DEF
);

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;
    logic             busy;

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );

endinterface

// File: rtl/rca_n.sv
// N-bit ripple-carry adder: a chain of full-adder cells, one per bit.
module rca_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: shift-and-add multiply per operand pair, then accumulate,
// with one shared ripple-carry adder time-multiplexed by state.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input logic           clk,
    input logic           rst_n,
    mac_seq_ctrl_if.slave bus
);

    localparam int unsigned CW = cnt_width(W);

    if (ACC_W < 2 * W) begin : g_bad_acc_w
        $error("mac_seq_ctrl: ACC_W must be at least 2*W");
    end

    state_t             state;
    state_t             state_nxt;
    logic [2*W-1:0]     mcand;
    logic [2*W-1:0]     product;
    logic [W-1:0]       mplier;
    logic [CW-1:0]      bit_cnt;
    logic [LEN_W-1:0]   remaining;
    logic [ACC_W-1:0]   acc;
    logic               ovf;

    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   add_b;
    logic [ACC_W-1:0]   add_sum;
    logic               add_cout;

    // Operand mux for the single adder: partial products in MUL, accumulate in ACC.
    always_comb begin
        add_a = '0;
        add_b = '0;
        unique case (state)
            MUL: begin
                add_a = ACC_W'(product);
                add_b = mplier[0] ? ACC_W'(mcand) : '0;
            end
            ACC: begin
                add_a = acc;
                add_b = ACC_W'(product);
            end
            default: ;
        endcase
    end

    rca_n #(.N(ACC_W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = (bus.len != '0) ? FETCH : DONE;
            end
            FETCH: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (bus_cnt_last()) state_nxt = ACC;
            end
            ACC: begin
                state_nxt = (remaining == LEN_W'(1)) ? DONE : FETCH;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    function automatic logic bus_cnt_last();
        return bit_cnt == CW'(W - 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            product   <= '0;
            mplier    <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= bus.len;
                    end
                end
                FETCH: begin
                    if (bus.in_valid) begin
                        mcand   <= (2*W)'(bus.a);
                        mplier  <= bus.b;
                        product <= '0;
                        bit_cnt <= '0;
                    end
                end
                MUL: begin
                    product <= add_sum[2*W-1:0];
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                ACC: begin
                    acc       <= add_sum;
                    remaining <= remaining - LEN_W'(1);
                    if (add_cout) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = acc;
    assign bus.overflow = ovf;

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the MAC datapath built from the team's full-adder cells.
- Accepts a stream of `len` unsigned operand pairs over a valid/ready handshake.
- Multiplies each pair by shift-and-add, then accumulates the product.
- A single shared ripple-carry adder does all the additions; this block time-multiplexes it between the multiply and accumulate steps.
- Returns the accumulated sum on an output valid/ready handshake. It sits between the operand source (memory/streaming front end) and the result consumer.

Parameters:
- W, 8: operand width of a and b (unsigned).
- ACC_W, 20: accumulator/result width. Must satisfy ACC_W >= 2*W; elaboration error otherwise.
- LEN_W, 8: width of the pair-count input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a job. Sampled only in IDLE.
- len  in  LEN_W  number of pairs in the job. Captured with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can take a pair. High only in FETCH.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- out_valid  out  1  result valid. High only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  ACC_W  accumulated sum, mod 2^ACC_W.
- overflow  out  1  sticky: some accumulate step carried out of ACC_W.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready, out_valid, busy, overflow = 0; result = 0.
  - All internal registers (acc, product, counters) = 0.
  - Reset mid-job abandons the job. No partial output is produced.
- States: IDLE, FETCH, MUL, ACC, DONE.
- IDLE:
  - start=1 with len!=0: capture len into remaining, clear acc and overflow, go to FETCH.
  - start=1 with len==0: clear acc and overflow, go to DONE (result=0).
- FETCH:
  - in_ready=1.
  - On in_valid&in_ready: latch a into mcand (zero-extended to 2W), latch b into mplier, clear product, bit_cnt=0, go to MUL.
  - in_valid low: stay in FETCH indefinitely.
- MUL: exactly W cycles.
  - Each cycle: product <= adder(product, mplier[0] ? mcand : 0); mcand <<= 1; mplier >>= 1; bit_cnt++.
  - After the cycle with bit_cnt==W-1, go to ACC.
- ACC: one cycle.
  - {carry, acc} <= adder(acc, zero-extended product).
  - carry=1 sets overflow (sticky); acc keeps the wrapped value.
  - Decrement remaining. If the decremented value is 0 go to DONE, else go to FETCH.
- DONE:
  - out_valid=1; result=acc, held stable until out_ready.
  - On out_ready go to IDLE.
  - start is ignored in DONE, including a start coincident with out_ready.
- start while busy is ignored (no restart, no effect on the current job).
- Shared adder:
  - One ACC_W-bit adder, carry-in 0.
  - Operand mux is selected by state (MUL: product/mcand; ACC: acc/product).
  - No other additions anywhere in the block.
  - The product register is 2W bits wide; it never overflows.
- Latency, with in_valid held high and no backpressure:
  - out_valid rises 1 + len*(W+2) cycles after the clock edge that samples start.
  - For len==0, out_valid rises 1 cycle after that edge.
- Throughput: W+2 cycles per pair, plus any in_valid stall cycles.
- in_valid/a/b are don't-care outside FETCH. out_ready is don't-care outside DONE.

Decomposition:
- mac_pkg holds:
  - state enum (IDLE, FETCH, MUL, ACC, DONE);
  - default W/ACC_W/LEN_W constants;
  - a function computing bit_cnt width, $clog2(W).
- One sub-module: rca_n.
  - Parameterised N-bit ripple-carry adder.
  - Generate-chain of the team's full-adder cell; ports a, b, cin, sum, cout.
  - Instantiated once, with N=ACC_W.

Test Plan:
- Single pair: W=8, start with len=1, a=3, b=5, in_valid high → out_valid at cycle 11 after the start edge, result=15, overflow=0.
- Four pairs of 255*255 → result=260100, overflow=0, out_valid at cycle 41.
- Overflow: 17 pairs of 255*255 with ACC_W=20 → overflow=1, result=56849 (1105425 mod 2^20).
- len=0 → out_valid on the cycle after start, result=0. Then out_ready → IDLE, busy=0.
- Backpressure and stalls:
  - in_valid low for 3 cycles in FETCH → in_ready stays 1 and the state holds.
  - out_ready low for 5 cycles in DONE → result and out_valid stable.
  - start pulses during MUL and during DONE are ignored.
- Reset mid-MUL: rst_n low asynchronously → all outputs 0 immediately. A new job, len=1 with 7*9, then yields 63 with correct latency.
